reorder_buffer: RTL and testbench

- Circular in-order retirement queue for the Tomasulo core.
- Allocates one entry per issued instruction and returns its ROB id to the issue stage, which uses that id as the register-file dependency tag.
- Collects results from the common data bus (CDB) and retires one instruction per cycle from the head.
- Retirement drives the register-file commit port (id/value/rob_id), releases stores to the LSB, and raises a global clear on branch mispredict.

---
 rtl/reorder_buffer_pkg.sv | 39 +++
 rtl/reorder_buffer_if.sv | 54 +++++
 rtl/rob_entry_array.sv | 115 +++++++++++
 rtl/reorder_buffer.sv | 132 +++++++++++++
 tb/tb_reorder_buffer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer: sizing, entry type
// encodings, the packed entry view and the mispredict test used at commit.
package reorder_buffer_pkg;

    localparam int ROB_INDEX_BIT = 4;
    localparam int ROB_SIZE      = 1 << ROB_INDEX_BIT;
    localparam int DATA_W        = 32;
    localparam int REG_W         = 5;

    // Destination register 0 means "no architectural write".
    localparam logic [REG_W-1:0] RD_NONE = '0;

    typedef logic [ROB_INDEX_BIT-1:0] rob_id_t;

    typedef enum logic [1:0] {
        TYPE_REG    = 2'd0,
        TYPE_STORE  = 2'd1,
        TYPE_BRANCH = 2'd2,
        TYPE_RSVD   = 2'd3
    } rob_type_e;

    typedef struct packed {
        logic              busy;
        logic              ready;
        rob_type_e         typ;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] value;
        logic              pred_jump;
        logic              actual_jump;
        logic [DATA_W-1:0] target;
    } rob_entry_t;

    // Indirect-jump targets are verified upstream by the decoder, so only a
    // direction disagreement forces a flush here.
    function automatic logic is_mispredict(input rob_entry_t e);
        return (e.typ == TYPE_BRANCH) && (e.actual_jump != e.pred_jump);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / CDB writeback / operand query / commit bundle between the ROB and
// the rest of the Tomasulo core.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic                issue_valid;
    logic [1:0]          issue_type;
    logic [REG_W-1:0]    issue_rd;
    logic                issue_pred_jump;
    logic                full;
    rob_id_t             issue_rob_id;

    logic                wb_valid;
    rob_id_t             wb_rob_id;
    logic [DATA_W-1:0]   wb_value;
    logic                wb_jump;
    logic [DATA_W-1:0]   wb_target;

    rob_id_t             qry_id1;
    rob_id_t             qry_id2;
    logic                qry_ready1;
    logic                qry_ready2;
    logic [DATA_W-1:0]   qry_val1;
    logic [DATA_W-1:0]   qry_val2;

    logic [REG_W-1:0]    rf_set_value_id;
    logic [DATA_W-1:0]   rf_set_value;
    rob_id_t             rf_set_value_rob_id;
    logic                store_commit;
    rob_id_t             store_commit_rob_id;
    logic                clear;
    logic [DATA_W-1:0]   clear_pc;

    modport master (
        output issue_valid, issue_type, issue_rd, issue_pred_jump,
        output wb_valid, wb_rob_id, wb_value, wb_jump, wb_target,
        output qry_id1, qry_id2,
        input  full, issue_rob_id,
        input  qry_ready1, qry_ready2, qry_val1, qry_val2,
        input  rf_set_value_id, rf_set_value, rf_set_value_rob_id,
        input  store_commit, store_commit_rob_id, clear, clear_pc
    );

    modport slave (
        input  issue_valid, issue_type, issue_rd, issue_pred_jump,
        input  wb_valid, wb_rob_id, wb_value, wb_jump, wb_target,
        input  qry_id1, qry_id2,
        output full, issue_rob_id,
        output qry_ready1, qry_ready2, qry_val1, qry_val2,
        output rf_set_value_id, rf_set_value, rf_set_value_rob_id,
        output store_commit, store_commit_rob_id, clear, clear_pc
    );

endinterface

// File: rtl/rob_entry_array.sv
// ROB entry storage: one allocate port, one CDB writeback port, two operand
// query ports with CDB forwarding, and a combinational head read.
module rob_entry_array
    import reorder_buffer_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush,
    input  logic              alloc_en,
    input  rob_id_t           alloc_idx,
    input  rob_type_e         alloc_type,
    input  logic [REG_W-1:0]  alloc_rd,
    input  logic              alloc_pred_jump,
    input  logic              release_en,
    input  logic              wb_valid,
    input  logic              wb_accept,
    input  rob_id_t           wb_idx,
    input  logic [DATA_W-1:0] wb_value,
    input  logic              wb_jump,
    input  logic [DATA_W-1:0] wb_target,
    input  rob_id_t           qry_id1,
    input  rob_id_t           qry_id2,
    output logic              qry_ready1,
    output logic              qry_ready2,
    output logic [DATA_W-1:0] qry_val1,
    output logic [DATA_W-1:0] qry_val2,
    input  rob_id_t           head_idx,
    output rob_entry_t        head_entry
);

    logic [ROB_SIZE-1:0] busy_q;
    logic [ROB_SIZE-1:0] ready_q;
    rob_type_e           type_q   [ROB_SIZE];
    logic [REG_W-1:0]    rd_q     [ROB_SIZE];
    logic [DATA_W-1:0]   value_q  [ROB_SIZE];
    logic                pjump_q  [ROB_SIZE];
    logic                ajump_q  [ROB_SIZE];
    logic [DATA_W-1:0]   target_q [ROB_SIZE];

    logic wb_write;
    logic fwd1, fwd2;

    function automatic logic [DATA_W-1:0] query_value(
        input logic              fwd,
        input logic              stored_ready,
        input logic [DATA_W-1:0] cdb_value,
        input logic [DATA_W-1:0] stored_value
    );
        if (fwd)
            return cdb_value;
        return stored_ready ? stored_value : '0;
    endfunction

    assign wb_write = wb_valid && wb_accept && busy_q[wb_idx] && !flush;

    // Control flags: release, then writeback, then allocate, so that a slot
    // freed and reallocated on the same edge ends up as a fresh entry.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy_q  <= '0;
            ready_q <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                busy_q  <= '0;
                ready_q <= '0;
            end else begin
                if (release_en) begin
                    busy_q[head_idx]  <= 1'b0;
                    ready_q[head_idx] <= 1'b0;
                end
                if (wb_write)
                    ready_q[wb_idx] <= 1'b1;
                if (alloc_en) begin
                    busy_q[alloc_idx]  <= 1'b1;
                    ready_q[alloc_idx] <= (alloc_type == TYPE_STORE);
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (wb_write) begin
                value_q[wb_idx]  <= wb_value;
                ajump_q[wb_idx]  <= wb_jump;
                target_q[wb_idx] <= wb_target;
            end
            if (alloc_en) begin
                type_q[alloc_idx]  <= alloc_type;
                rd_q[alloc_idx]    <= alloc_rd;
                pjump_q[alloc_idx] <= alloc_pred_jump;
            end
        end
    end

    assign fwd1       = wb_valid && (wb_idx == qry_id1);
    assign fwd2       = wb_valid && (wb_idx == qry_id2);
    assign qry_ready1 = ready_q[qry_id1] || fwd1;
    assign qry_ready2 = ready_q[qry_id2] || fwd2;
    assign qry_val1   = query_value(fwd1, ready_q[qry_id1], wb_value, value_q[qry_id1]);
    assign qry_val2   = query_value(fwd2, ready_q[qry_id2], wb_value, value_q[qry_id2]);

    assign head_entry = '{
        busy:        busy_q[head_idx],
        ready:       ready_q[head_idx],
        typ:         type_q[head_idx],
        rd:          rd_q[head_idx],
        value:       value_q[head_idx],
        pred_jump:   pjump_q[head_idx],
        actual_jump: ajump_q[head_idx],
        target:      target_q[head_idx]
    };

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates ids at issue, collects CDB
// results, retires one entry per cycle and flushes on branch mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    reorder_buffer_if.slave rob
);

    typedef logic [ROB_INDEX_BIT:0] cnt_t;

    rob_id_t           head_q;
    rob_id_t           tail_q;
    cnt_t              count_q;
    cnt_t              count_next;
    rob_entry_t        head_e;

    logic              commit_now;
    logic              flush_now;
    logic              issue_now;

    logic              full_p1;
    logic [REG_W-1:0]  rf_id_p1;
    logic [DATA_W-1:0] rf_val_p1;
    rob_id_t           rf_rob_p1;
    logic              st_p1;
    rob_id_t           st_id_p1;
    logic              clear_p1;
    logic [DATA_W-1:0] clear_pc_p1;

    // A full buffer still accepts an issue on the edge that retires the head.
    assign commit_now = (count_q != '0) && head_e.busy && head_e.ready;
    assign flush_now  = commit_now && is_mispredict(head_e);
    assign issue_now  = rob.issue_valid && (!full_p1 || commit_now) && !clear_p1 && !flush_now;
    assign count_next = count_q + cnt_t'(issue_now) - cnt_t'(commit_now);

    rob_entry_array u_entries (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .flush           (flush_now),
        .alloc_en        (issue_now),
        .alloc_idx       (tail_q),
        .alloc_type      (rob_type_e'(rob.issue_type)),
        .alloc_rd        (rob.issue_rd),
        .alloc_pred_jump (rob.issue_pred_jump),
        .release_en      (commit_now),
        .wb_valid        (rob.wb_valid),
        .wb_accept       (!clear_p1),
        .wb_idx          (rob.wb_rob_id),
        .wb_value        (rob.wb_value),
        .wb_jump         (rob.wb_jump),
        .wb_target       (rob.wb_target),
        .qry_id1         (rob.qry_id1),
        .qry_id2         (rob.qry_id2),
        .qry_ready1      (rob.qry_ready1),
        .qry_ready2      (rob.qry_ready2),
        .qry_val1        (rob.qry_val1),
        .qry_val2        (rob.qry_val2),
        .head_idx        (head_q),
        .head_entry      (head_e)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_p1 <= 1'b0;
        end else if (rdy_in) begin
            if (flush_now) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                full_p1 <= 1'b0;
            end else begin
                head_q  <= head_q + rob_id_t'(commit_now);
                tail_q  <= tail_q + rob_id_t'(issue_now);
                count_q <= count_next;
                full_p1 <= (count_next == cnt_t'(ROB_SIZE));
            end
        end
    end

    // Commit stage: outputs are valid for the one cycle after the retiring edge.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rf_id_p1    <= RD_NONE;
            rf_val_p1   <= '0;
            rf_rob_p1   <= '0;
            st_p1       <= 1'b0;
            st_id_p1    <= '0;
            clear_p1    <= 1'b0;
            clear_pc_p1 <= '0;
        end else if (rdy_in) begin
            rf_id_p1 <= RD_NONE;
            st_p1    <= 1'b0;
            clear_p1 <= 1'b0;
            if (commit_now) begin
                unique case (head_e.typ)
                    TYPE_REG, TYPE_BRANCH: begin
                        rf_id_p1  <= head_e.rd;
                        rf_val_p1 <= head_e.value;
                        rf_rob_p1 <= head_q;
                    end
                    TYPE_STORE: begin
                        st_p1    <= 1'b1;
                        st_id_p1 <= head_q;
                    end
                    default: ;
                endcase
                if (flush_now) begin
                    clear_p1    <= 1'b1;
                    clear_pc_p1 <= head_e.target;
                end
            end
        end
    end

    assign rob.full                = full_p1;
    assign rob.issue_rob_id        = tail_q;
    assign rob.rf_set_value_id     = rf_id_p1;
    assign rob.rf_set_value        = rf_val_p1;
    assign rob.rf_set_value_rob_id = rf_rob_p1;
    assign rob.store_commit        = st_p1;
    assign rob.store_commit_rob_id = st_id_p1;
    assign rob.clear               = clear_p1;
    assign rob.clear_pc            = clear_pc_p1;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected commits are queued at issue
// and compared in order whenever the commit port shows activity.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;

    reorder_buffer_if rif ();

    reorder_buffer dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .rob    (rif)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        st;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [3:0]  id;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic st, input logic [4:0] rd, input logic [31:0] val,
                            input logic [3:0] id);
        exp_t e;
        e.st = st; e.rd = rd; e.val = val; e.id = id;
        exp_q.push_back(e);
    endtask

    // Advance one edge, then compare any commit activity with the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk_in);
        #1;
        if (rif.rf_set_value_id != 5'd0 || rif.store_commit) begin
            if (exp_q.size() == 0) begin
                check("spurious_commit", {rif.store_commit, rif.rf_set_value_id}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("commit_is_store", rif.store_commit, e.st);
                if (e.st) begin
                    check("commit_store_id", rif.store_commit_rob_id, e.id);
                end else begin
                    check("commit_rd", rif.rf_set_value_id, e.rd);
                    check("commit_val", rif.rf_set_value, e.val);
                    check("commit_rob_id", rif.rf_set_value_rob_id, e.id);
                end
            end
        end
    endtask

    task automatic idle();
        rif.issue_valid = 1'b0;
        rif.wb_valid    = 1'b0;
    endtask

    task automatic set_issue(input logic [1:0] t, input logic [4:0] rd, input logic pj);
        rif.issue_valid     = 1'b1;
        rif.issue_type      = t;
        rif.issue_rd        = rd;
        rif.issue_pred_jump = pj;
    endtask

    task automatic set_wb(input logic [3:0] id, input logic [31:0] v, input logic j,
                          input logic [31:0] tgt);
        rif.wb_valid  = 1'b1;
        rif.wb_rob_id = id;
        rif.wb_value  = v;
        rif.wb_jump   = j;
        rif.wb_target = tgt;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
        exp_q.delete();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++)
            tick();
        check("sb_drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        rif.issue_valid = 0; rif.issue_type = 0; rif.issue_rd = 0; rif.issue_pred_jump = 0;
        rif.wb_valid = 0; rif.wb_rob_id = 0; rif.wb_value = 0; rif.wb_jump = 0; rif.wb_target = 0;
        rif.qry_id1 = 0; rif.qry_id2 = 0;

        // Reset state
        do_reset();
        check("rst_full", rif.full, 0);
        check("rst_issue_id", rif.issue_rob_id, 0);
        check("rst_rf_id", rif.rf_set_value_id, 0);
        check("rst_rf_val", rif.rf_set_value, 0);
        check("rst_rf_rob", rif.rf_set_value_rob_id, 0);
        check("rst_store", {rif.store_commit, rif.store_commit_rob_id}, 0);
        check("rst_clear", {rif.clear, rif.clear_pc}, 0);
        check("rst_qry", {rif.qry_ready1, rif.qry_ready2, rif.qry_val1, rif.qry_val2}, 0);

        // Single reg-write: 1-cycle writeback-to-commit latency, one-cycle pulse
        check("t1_issue_id", rif.issue_rob_id, 0);
        set_issue(TYPE_REG, 5'd5, 1'b0);
        push_exp(1'b0, 5'd5, 32'h1234, 4'd0);
        tick(); idle();
        set_wb(4'd0, 32'h1234, 1'b0, 32'h0);
        tick(); idle();
        check("t1_wb_latency", rif.rf_set_value_id, 0);
        tick();
        check("t1_committed", exp_q.size(), 0);
        tick();
        check("t1_one_cycle", rif.rf_set_value_id, 0);
        drain(4);

        // Out-of-order writeback, in-order retirement, store ready at issue
        do_reset();
        set_issue(TYPE_REG, 5'd3, 1'b0);   push_exp(1'b0, 5'd3, 32'hA, 4'd0); tick();
        set_issue(TYPE_REG, 5'd4, 1'b0);   push_exp(1'b0, 5'd4, 32'hB, 4'd1); tick();
        set_issue(TYPE_STORE, 5'd0, 1'b0); push_exp(1'b1, 5'd0, 32'h0, 4'd2); tick();
        idle();
        set_wb(4'd1, 32'hB, 1'b0, 32'h0);
        tick();
        check("t2_no_early", {rif.store_commit, rif.rf_set_value_id}, 0);
        set_wb(4'd0, 32'hA, 1'b0, 32'h0);
        tick(); idle();
        tick();
        check("t2_after_id0", exp_q.size(), 2);
        tick();
        check("t2_after_id1", exp_q.size(), 1);
        tick();
        check("t2_after_store", exp_q.size(), 0);
        drain(4);

        // Fill all 16 entries, drop a 17th, then issue while retiring the head
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_issue(TYPE_REG, 5'(i + 1), 1'b0);
            push_exp(1'b0, 5'(i + 1), 32'h100 + 32'(i), 4'(i));
            tick();
        end
        idle();
        check("t3_full", rif.full, 1);
        check("t3_tail_wrap", rif.issue_rob_id, 0);
        set_issue(TYPE_REG, 5'd30, 1'b0);
        tick(); idle();
        check("t3_drop_full", rif.full, 1);
        check("t3_drop_tail", rif.issue_rob_id, 0);
        set_wb(4'd0, 32'h100, 1'b0, 32'h0);
        tick(); idle();
        set_issue(TYPE_REG, 5'd20, 1'b0);
        push_exp(1'b0, 5'd20, 32'h555, 4'd0);
        tick(); idle();
        check("t3_full_hold", rif.full, 1);
        check("t3_tail_after", rif.issue_rob_id, 1);
        for (int i = 1; i < 16; i++) begin
            set_wb(4'(i), 32'h100 + 32'(i), 1'b0, 32'h0);
            tick();
        end
        set_wb(4'd0, 32'h555, 1'b0, 32'h0);
        tick(); idle();
        drain(20);
        check("t3_drained_full", rif.full, 0);

        // Mispredicted branch at head with 3 younger entries
        do_reset();
        set_issue(TYPE_BRANCH, 5'd0, 1'b0); tick();
        set_issue(TYPE_REG, 5'd7, 1'b0); tick();
        set_issue(TYPE_REG, 5'd8, 1'b0); tick();
        set_issue(TYPE_REG, 5'd9, 1'b0); tick();
        idle();
        for (int i = 1; i < 4; i++) begin
            set_wb(4'(i), 32'h900 + 32'(i), 1'b0, 32'h0);
            tick();
        end
        set_wb(4'd0, 32'h0, 1'b1, 32'h100);
        tick(); idle();
        tick();
        check("t4_clear", rif.clear, 1);
        check("t4_clear_pc", rif.clear_pc, 32'h100);
        check("t4_issue_id", rif.issue_rob_id, 0);
        check("t4_full", rif.full, 0);
        set_issue(TYPE_REG, 5'd11, 1'b0);
        set_wb(4'd1, 32'hDEAD, 1'b0, 32'h0);
        tick(); idle();
        check("t4_clear_pulse", rif.clear, 0);
        check("t4_issue_blocked", rif.issue_rob_id, 0);
        for (int i = 0; i < 4; i++) tick();
        // Correctly predicted JAL writes its link register without a flush
        set_issue(TYPE_BRANCH, 5'd1, 1'b1);
        push_exp(1'b0, 5'd1, 32'h44, 4'd0);
        tick(); idle();
        set_wb(4'd0, 32'h44, 1'b1, 32'h200);
        tick(); idle();
        tick();
        check("t4_jal_no_clear", rif.clear, 0);
        drain(4);

        // Query forwarding and rdy_in hold
        do_reset();
        set_issue(TYPE_REG, 5'd1, 1'b0); push_exp(1'b0, 5'd1, 32'h70, 4'd0); tick();
        set_issue(TYPE_REG, 5'd2, 1'b0); push_exp(1'b0, 5'd2, 32'h71, 4'd1); tick();
        set_issue(TYPE_REG, 5'd3, 1'b0); push_exp(1'b0, 5'd3, 32'h7, 4'd2); tick();
        idle();
        rif.qry_id1 = 4'd2;
        rif.qry_id2 = 4'd0;
        set_wb(4'd2, 32'h7, 1'b0, 32'h0);
        #1;
        check("t5_fwd_ready", rif.qry_ready1, 1);
        check("t5_fwd_val", rif.qry_val1, 32'h7);
        check("t5_other_ready", rif.qry_ready2, 0);
        tick(); idle();
        #1;
        check("t5_stored_ready", rif.qry_ready1, 1);
        check("t5_stored_val", rif.qry_val1, 32'h7);
        rdy_in = 1'b0;
        set_wb(4'd0, 32'h70, 1'b0, 32'h0);
        set_issue(TYPE_REG, 5'd6, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        idle();
        #1;
        check("t5_hold_wb", rif.qry_ready2, 0);
        check("t5_hold_tail", rif.issue_rob_id, 3);
        check("t5_hold_queue", exp_q.size(), 3);
        rdy_in = 1'b1;
        set_wb(4'd0, 32'h70, 1'b0, 32'h0); tick();
        set_wb(4'd1, 32'h71, 1'b0, 32'h0); tick();
        idle();
        drain(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
